// File: rtl/fp_wb_stage.sv
// fp_wb_stage: 2-entry writeback FIFO for FPU results with a registered head.
// Define FP_WB_NANBOX_EN to NaN-box F32 results (upper word all ones).
// When it is undefined, the upper word of an F32 result is zero-filled.
module fp_wb_stage #(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_result,
    input  logic [1:0]       in_fmt,
    input  logic [TAG_W-1:0] in_rd,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [TAG_W-1:0] out_rd,
    output logic [1:0]       occupancy,
    output logic [7:0]       fmt_err_cnt
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned CNT_W  = 2;

`ifdef FP_WB_NANBOX_EN
    localparam logic [31:0] F32_UPPER = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] F32_UPPER = 32'h0000_0000;
`endif

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [TAG_W-1:0]  tag_d  [DEPTH];
    // Wrap counters; bit 0 is the storage pointer, the difference is the occupancy.
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [1:0]        occ_q, occ_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [TAG_W-1:0]  out_rd_q, out_rd_d;
    logic [7:0]        err_q, err_d;

    logic              push_c;
    logic              pop_c;
    logic              fmt_bad_c;
    logic [DATA_W-1:0] fmt_data_c;

    // Format the incoming result as it will be stored.
    always_comb begin
        fmt_data_c = '0;
        fmt_bad_c  = 1'b0;
        case (in_fmt)
            2'd0:    fmt_data_c = {F32_UPPER, in_result[31:0]};
            2'd1:    fmt_data_c = in_result;
            default: fmt_bad_c  = 1'b1;
        endcase
    end

    assign push_c = in_valid & in_ready_q;
    assign pop_c  = out_valid_q & out_ready;

    // Next-state for storage, pointers, error counter and the registered head.
    always_comb begin
        data_d   = data_q;
        tag_d    = tag_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        err_d    = err_q;
        if (flush) begin
            rd_cnt_d = wr_cnt_q;
        end else begin
            if (push_c) begin
                data_d[wr_cnt_q[0]] = fmt_data_c;
                tag_d[wr_cnt_q[0]]  = in_rd;
                wr_cnt_d            = wr_cnt_q + CNT_W'(1);
                if (fmt_bad_c && (err_q != 8'hFF)) begin
                    err_d = err_q + 8'd1;
                end
            end
            if (pop_c) begin
                rd_cnt_d = rd_cnt_q + CNT_W'(1);
            end
        end
        occ_d       = 2'(wr_cnt_d - rd_cnt_d);
        in_ready_d  = (occ_d != 2'd2);
        out_valid_d = (occ_d != 2'd0);
        out_data_d  = '0;
        out_rd_d    = '0;
        if (occ_d != 2'd0) begin
            out_data_d = data_d[rd_cnt_d[0]];
            out_rd_d   = tag_d[rd_cnt_d[0]];
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            occ_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            err_q       <= '0;
        end else begin
            data_q      <= data_d;
            tag_q       <= tag_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            occ_q       <= occ_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
            err_q       <= err_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_rd      = out_rd_q;
    assign occupancy   = occ_q;
    assign fmt_err_cnt = err_q;

endmodule

// File: tb/tb_fp_wb_stage.sv
// tb_fp_wb_stage: directed and random checks of fp_wb_stage against a queue model.
module tb_fp_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_result;
    logic [1:0]  in_fmt;
    logic [4:0]  in_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic [1:0]  occupancy;
    logic [7:0]  fmt_err_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [63:0] d;
        logic [4:0]  r;
    } ent_t;

    ent_t q[$];
    int   m_err = 0;

`ifdef FP_WB_NANBOX_EN
    localparam logic [31:0] UPPER = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] UPPER = 32'h0;
`endif

    fp_wb_stage #(.TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_fmt(in_fmt), .in_rd(in_rd),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd),
        .occupancy(occupancy), .fmt_err_cnt(fmt_err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] fmt_val(logic [63:0] r, logic [1:0] f);
        if (f == 2'd0) return {UPPER, r[31:0]};
        if (f == 2'd1) return r;
        return 64'd0;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(string tag);
        int sz = q.size();
        chk({tag, ".occupancy"}, 64'(occupancy), 64'(sz));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(sz != 0));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(sz != 2));
        chk({tag, ".fmt_err_cnt"}, 64'(fmt_err_cnt), 64'(m_err));
        if (sz != 0) begin
            chk({tag, ".out_data"}, out_data, q[0].d);
            chk({tag, ".out_rd"}, 64'(out_rd), 64'(q[0].r));
        end
    endtask

    // One clock: model update from the inputs presented, then check after the edge.
    task automatic cyc(string tag);
        bit push = in_valid && (q.size() < 2);
        bit pop  = (q.size() > 0) && out_ready;
        ent_t e;
        e.d = fmt_val(in_result, in_fmt);
        e.r = in_rd;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(e);
                if (in_fmt > 2'd1 && m_err < 255) m_err++;
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic drive(bit v, logic [63:0] r, logic [1:0] f, logic [4:0] rd);
        in_valid  = v;
        in_result = r;
        in_fmt    = f;
        in_rd     = rd;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 64'd0, 2'd0, 5'd0);
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("reset.occupancy", 64'(occupancy), 64'd0);
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        chk("reset.fmt_err_cnt", 64'(fmt_err_cnt), 64'd0);
        chk("reset.out_data", out_data, 64'd0);
        chk("reset.out_rd", 64'(out_rd), 64'd0);
        rst_n = 1'b1;

        // F32 formatting, pushed on the first edge after reset release.
        out_ready = 1'b1;
        drive(1'b1, 64'h0000_0000_BF80_0000, 2'd0, 5'd5);
        cyc("f32");
        drive(1'b0, 64'd0, 2'd0, 5'd0);
`ifdef FP_WB_NANBOX_EN
        chk("nanbox.data", out_data, 64'hFFFF_FFFF_BF80_0000);
`else
        chk("zerofill.data", out_data, 64'h0000_0000_BF80_0000);
`endif
        chk("f32.rd", 64'(out_rd), 64'd5);
        cyc("f32.pop");
        drive(1'b1, 64'h0000_0000_3F80_0000, 2'd0, 5'd6);
        cyc("f32b");
        drive(1'b0, 64'd0, 2'd0, 5'd0);
        chk("f32b.data", out_data, {UPPER, 32'h3F80_0000});
        cyc("f32b.pop");

        // F64 pass-through held under a 3-cycle stall.
        out_ready = 1'b0;
        drive(1'b1, 64'h8000_0000_0000_0001, 2'd1, 5'd9);
        cyc("f64.push");
        drive(1'b0, 64'd0, 2'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            cyc("f64.stall");
            chk("f64.hold", out_data, 64'h8000_0000_0000_0001);
        end
        out_ready = 1'b1;
        cyc("f64.pop");

        // Fill to two, reject a third, then drain in order.
        out_ready = 1'b0;
        drive(1'b1, 64'h11, 2'd1, 5'd1);
        cyc("full.p1");
        drive(1'b1, 64'h22, 2'd1, 5'd2);
        cyc("full.p2");
        drive(1'b1, 64'h33, 2'd1, 5'd3);
        cyc("full.p3");
        chk("full.in_ready", 64'(in_ready), 64'd0);
        drive(1'b0, 64'd0, 2'd0, 5'd0);
        out_ready = 1'b1;
        cyc("drain1");
        chk("drain1.rd", 64'(out_rd), 64'd2);
        cyc("drain2");
        chk("drain2.empty", 64'(out_valid), 64'd0);

        // Push and pop together at occupancy 1, then flush with a live input.
        out_ready = 1'b0;
        drive(1'b1, 64'hA, 2'd1, 5'd10);
        cyc("pp.fill");
        out_ready = 1'b1;
        drive(1'b1, 64'hB, 2'd1, 5'd11);
        cyc("pp.both");
        chk("pp.head", 64'(out_rd), 64'd11);
        drive(1'b1, 64'hC, 2'd2, 5'd12);
        flush = 1'b1;
        cyc("flush");
        flush = 1'b0;
        drive(1'b0, 64'd0, 2'd0, 5'd0);
        chk("flush.err", 64'(fmt_err_cnt), 64'd0);

        // Invalid format: 257 accepted pushes saturate the error counter.
        out_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            drive(1'b1, {$urandom, $urandom}, 2'(2 + (i % 2)), 5'($urandom));
            cyc("badfmt");
        end
        chk("badfmt.sat", 64'(fmt_err_cnt), 64'd255);

        // Asynchronous reset pulse while data is buffered.
        out_ready = 1'b0;
        drive(1'b1, 64'h55, 2'd1, 5'd7);
        cyc("mid.push");
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        m_err = 0;
        chk("arst.err", 64'(fmt_err_cnt), 64'd0);
        chk("arst.valid", 64'(out_valid), 64'd0);
        check_all("arst");
        rst_n = 1'b1;
        drive(1'b0, 64'd0, 2'd0, 5'd0);

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), {$urandom, $urandom}, 2'($urandom), 5'($urandom));
            out_ready = 1'($urandom);
            flush     = ($urandom_range(0, 19) == 0);
            cyc("rand");
        end
        flush = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_wb_stage.md
FP_WB_STAGE -- requirements
Module: fp_wb_stage

Interface
REQ-001 SHALL have parameter TAG_W, default 5: width of the destination-register tag.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream result valid; source is the sign-inject result plus its fmt and tag.
REQ-005 SHALL have port in_ready, output, 1 bit: stage can accept a result.
REQ-006 SHALL have port in_result, input, 64 bits: raw FPU result; F32 values occupy [31:0].
REQ-007 SHALL have port in_fmt, input, 2 bits: format code, 0 = F32, 1 = F64, 2/3 = invalid.
REQ-008 SHALL have port in_rd, input, TAG_W bits: destination register tag.
REQ-009 SHALL have port flush, input, 1 bit: synchronous discard of all buffered entries.
REQ-010 SHALL have port out_valid, output, 1 bit: writeback entry valid.
REQ-011 SHALL have port out_ready, input, 1 bit: register file accepts the entry.
REQ-012 SHALL have port out_data, output, 64 bits: formatted writeback value.
REQ-013 SHALL have port out_rd, output, TAG_W bits: tag of the head entry.
REQ-014 SHALL have port occupancy, output, 2 bits: buffered entry count, 0 to 2.
REQ-015 SHALL have port fmt_err_cnt, output, 8 bits: saturating count of accepted entries with invalid fmt.

Function
REQ-016 SHALL implement a 2-entry FIFO of {data[63:0], rd}, with a registered head driving out_data and out_rd.
REQ-017 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-018 SHALL drive in_ready = (occupancy != 2), with no combinational path from out_ready.
REQ-019 SHALL drive out_valid = (occupancy != 0).
REQ-020 SHALL have a minimum latency of 1 cycle: a result accepted in cycle N into an empty FIFO is presented in cycle N+1.
REQ-021 SHALL form the stored data at push time as follows:
  - fmt 0: the formatted-F32 rule of REQ-033.
  - fmt 1: in_result unchanged.
  - fmt 2/3: all zeros, and fmt_err_cnt increments, saturating at 255.
REQ-022 SHALL handle simultaneous push and pop with occupancy 1 as: occupancy stays 1, the new entry becomes head in the next cycle, and no entry is lost.
REQ-023 SHALL NOT accept a push when occupancy is 2, because in_ready is low; a pop in that cycle leaves occupancy at 1.
REQ-024 SHALL maintain strict FIFO order: the oldest entry is always at the head.
REQ-025 SHALL hold out_data and out_rd stable while out_valid = 1 and out_ready = 0.
REQ-026 SHALL give flush priority over push and pop in the same cycle: occupancy becomes 0 next cycle, the input is not stored, and fmt_err_cnt is unchanged by that input.
REQ-027 SHALL have fmt_err_cnt unaffected by flush or pop; it clears only on reset.
REQ-028 SHALL keep the storage pointers 1-bit and wrapping modulo 2, with occupancy derived as write count minus read count.

Reset
REQ-029 SHALL, while rst_n = 0, immediately drive occupancy = 0, out_valid = 0, in_ready = 1, fmt_err_cnt = 0, out_data = 0 and out_rd = 0.
REQ-030 SHALL, on reset assertion mid-transfer, discard all buffered entries with no partial output.
REQ-031 SHALL permit the first push in the first rising edge after rst_n deasserts.

Configuration
REQ-032 SHALL use macro FP_WB_NANBOX_EN to select F32 formatting.
REQ-033 SHALL, when FP_WB_NANBOX_EN is defined, store fmt-0 entries as {32'hFFFF_FFFF, in_result[31:0]} (RISC-V NaN-boxing).
REQ-034 SHALL, when FP_WB_NANBOX_EN is undefined, store fmt-0 entries as {32'h0, in_result[31:0]}, with all other behaviour identical.

Verification
REQ-035 SHALL cover NaN-box: macro defined, push in_result=64'h0000_0000_BF80_0000, fmt=0, rd=5, out_ready=1 -> next cycle out_valid=1, out_data=64'hFFFF_FFFF_BF80_0000, out_rd=5.
REQ-036 SHALL cover F64 pass-through with a stall: push 64'h8000_0000_0000_0001, fmt=1, out_ready=0 for 3 cycles -> out_data holds that value for 3 cycles and pops when out_ready=1.
REQ-037 SHALL cover full and back-pressure: out_ready=0, push rd=1 then rd=2 -> occupancy=2, in_ready=0, a third in_valid is ignored; then out_ready=1 -> rd 1 then rd 2 in order.
REQ-038 SHALL cover simultaneous push/pop plus flush: occupancy=1 with push and pop in the same cycle -> occupancy stays 1; then flush with in_valid=1 -> occupancy=0, out_valid=0 next cycle.
REQ-039 SHALL cover invalid fmt: 257 pushes with fmt=2 -> out_data=0 for each and fmt_err_cnt saturates at 255; async rst_n pulse mid-stream -> fmt_err_cnt=0 and out_valid=0 with no clock edge required.
REQ-040 SHALL cover the macro undefined: fmt-0 push of 64'h0000_0000_3F80_0000 -> out_data=64'h0000_0000_3F80_0000.
